bcd_bin: RTL
============

// Module: bcd_bin
// PURPOSE
//   Sequential BCD-to-binary converter: the inverse of the binary-to-BCD path.
//   Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from every digit >= 8.
//   Takes packed DIGITS-digit BCD words (for example from a keypad or display register),
//   and returns unsigned binary over a valid/ready handshake.
// PARAMETERS
//   DIGITS  3   number of BCD digits in; input width is 4*DIGITS
//   BIN_W   10  output width; must satisfy 2**BIN_W > 10**DIGITS-1 (elaboration $error otherwise)
// PORTS
//   clk        in   1           single clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   in_valid   in   1           bcd_in valid
//   in_ready   out  1           converter idle, can accept
//   bcd_in     in   4*DIGITS    packed BCD, digit 0 (ones) in [3:0]
//   out_valid  out  1           bin_out (and err) valid
//   out_ready  in   1           consumer accepts result
//   bin_out    out  BIN_W       binary result
//   busy       out  1           conversion in progress (state CONV)
//   err        out  1           invalid digit seen; present only with BCD_BIN_ERR_EN
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, bin_out=0, err=0, count=0.
//   Work register: {bcd[4*DIGITS-1:0], shbin[4*DIGITS-1:0]}, 8*DIGITS bits.
//   FSM states:
//     IDLE: in_ready=1. When in_valid&&in_ready at an edge: load bcd=bcd_in, shbin=0, count=0 -> CONV.
//     CONV: in_ready=0, busy=1. Each cycle:
//       - shift the whole register right by 1;
//       - then, for each shifted digit >= 8, subtract 3 (4-bit, no carry between digits);
//       - count++.
//       After step 4*DIGITS (count == 4*DIGITS-1 at the edge): latch bin_out = shbin[BIN_W-1:0] -> DONE.
//     DONE: out_valid=1; bin_out stable. On out_ready at an edge: -> IDLE, out_valid=0.
//       No new input is accepted in DONE.
//   Latency: out_valid rises exactly 4*DIGITS clock edges after the accept edge (12 for DIGITS=3).
//   Throughput: 1 word per 4*DIGITS+2 cycles when out_ready is held high.
//   out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored; bcd_in is sampled only at accept.
//   bin_out holds its last value in IDLE/CONV; only out_valid qualifies it.
//   shbin bits above BIN_W are discarded; the parameter rule guarantees they are zero.
//   Reset mid-CONV or in DONE: conversion is abandoned; no out_valid pulse follows.
// CONFIGURATION
//   BCD_BIN_ERR_EN defined:
//     - at accept, err_next = OR over digits of (digit > 9);
//     - the flag is carried through CONV and presented as err with out_valid;
//     - when err=1, bin_out is forced to 0;
//     - err clears on leaving DONE.
//   BCD_BIN_ERR_EN undefined:
//     - err port absent; no digit checking;
//     - invalid digits convert to an unspecified value with normal timing.
// TESTING  (DIGITS=3, BIN_W=10)
//   bcd_in=12'h999, out_ready=1 -> bin_out=10'd999 (0x3E7), out_valid 12 edges after accept, 1-cycle pulse.
//   bcd_in=12'h000 then 12'h255 back-to-back -> 0 then 255; second accept 1 cycle after the first DONE exit.
//   bcd_in=12'h407, out_ready=0 for 20 cycles -> out_valid and bin_out=407 held stable, in_ready=0 throughout;
//     release -> IDLE next edge.
//   Assert rst at CONV count=5 after accepting 12'h123 -> immediate in_ready=1, busy=0, out_valid=0;
//     next word 12'h001 -> 1.
//   BCD_BIN_ERR_EN: bcd_in=12'h1A3 -> out_valid with err=1, bin_out=0;
//     following 12'h042 -> err=0, bin_out=42.
//   in_valid toggled during CONV with garbage bcd_in -> ignored; result matches the originally accepted word.

Source files
------------

// File: rtl/bcd_bin.sv
// bcd_bin: serial BCD-to-binary converter (reverse double-dabble), valid/ready in and out.
// Ports: clk, rst (async high), in_valid/in_ready/bcd_in, out_valid/out_ready/bin_out, busy, err (BCD_BIN_ERR_EN only).
module bcd_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                busy
`ifdef BCD_BIN_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  if ((64'd10 ** DIGITS) - 64'd1 >= (64'd1 << BIN_W)) begin : g_bad_cfg
    $error("bcd_bin: BIN_W too narrow for DIGITS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2*W-1:0]    work_q, work_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [2*W-1:0]    work_step;
  logic [BIN_W-1:0]  step_bin;

`ifdef BCD_BIN_ERR_EN
  logic err_flag_q, err_flag_d;
  logic err_q, err_d;
  logic bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end
`endif

  // One reverse double-dabble step: shift right, then pull
  // each BCD digit that now reads >= 8 back down by 3.
  always_comb begin
    work_step = work_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_step[W+4*i +: 4] >= 4'd8) begin
        work_step[W+4*i +: 4] = work_step[W+4*i +: 4] - 4'd3;
      end
    end
    step_bin = BIN_W'(work_step[W-1:0]);
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    bin_d       = bin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef BCD_BIN_ERR_EN
    err_flag_d  = err_flag_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d     = {bcd_in, {W{1'b0}}};
          count_d    = '0;
          state_d    = CONV;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef BCD_BIN_ERR_EN
          err_flag_d = bcd_bad;
`endif
        end
      end
      CONV: begin
        work_d  = work_step;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
`ifdef BCD_BIN_ERR_EN
          err_d = err_flag_q;
          bin_d = err_flag_q ? '0 : step_bin;
`else
          bin_d = step_bin;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef BCD_BIN_ERR_EN
          err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      count_q     <= '0;
      bin_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BCD_BIN_ERR_EN
      err_flag_q  <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      bin_q       <= bin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef BCD_BIN_ERR_EN
      err_flag_q  <= err_flag_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign busy      = busy_q;
`ifdef BCD_BIN_ERR_EN
  assign err       = err_q;
`endif

endmodule
